// File: rtl/crash_text_pkg.sv
// crash_text_pkg: shared types, widths and 8x16 glyph table for the crash banner
package crash_text_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLINK_ON = 2'd2, BLINK_OFF = 2'd3} state_t;
  localparam int RGB_W = 12;
  localparam int FONT_ADDR_W = 11;
  localparam int FONT_COLS = 8;
  localparam logic [RGB_W-1:0] RGB_BLACK = '0;
  // 16 rows of 8 pixels per glyph, row 0 in the top byte; unlisted codes are blank
  function automatic logic [127:0] glyph(input logic [6:0] c);
    case (c)
      7'h21: glyph = 128'h0000183c3c3c18181800181800000000;
      7'h41: glyph = 128'h000010386cc6c6fec6c6c6c600000000;
      7'h43: glyph = 128'h00003c66c2c0c0c0c0c2663c00000000;
      7'h44: glyph = 128'h0000f86c6666666666666cf800000000;
      7'h45: glyph = 128'h0000fe6662687868606266fe00000000;
      7'h48: glyph = 128'h0000c6c6c6c6fec6c6c6c6c600000000;
      7'h52: glyph = 128'h0000fc6666667c6c666666e600000000;
      7'h53: glyph = 128'h00007cc6c660380c06c6c67c00000000;
      default: glyph = '0;
    endcase
  endfunction
endpackage

// File: rtl/crash_font_rom.sv
// crash_font_rom: 2048x8 synchronous-read font ROM, address {char[6:0], row[3:0]}
module crash_font_rom import crash_text_pkg::*; (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [FONT_ADDR_W-1:0] i_addr,
  output logic [FONT_COLS-1:0]   o_data
);
  logic [127:0] w_sh;
  assign w_sh = glyph(i_addr[10:4]) << {i_addr[3:0], 3'b000};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) o_data <= '0;
    else o_data <= w_sh[127 -: FONT_COLS];
endmodule

// File: rtl/crash_text_renderer.sv
// crash_text_renderer: font lookup, banner colour mix and crash banner FSM; CRASH_TEXT_BLINK_EN enables blinking
module crash_text_renderer import crash_text_pkg::*; #(
  parameter int               SHOW_FRAMES  = 120,
  parameter int               BLINK_FRAMES = 30,
  parameter logic [RGB_W-1:0] TEXT_RGB     = 12'hF00
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   crash_en,
  input  logic                   frame_tick,
  input  logic                   crash_on,
  input  logic [FONT_ADDR_W-1:0] crash_rom_addr,
  input  logic [2:0]             crash_bit_addr,
  input  logic                   video_on,
  input  logic [RGB_W-1:0]       bg_rgb,
  output logic [RGB_W-1:0]       rgb_out,
  output logic                   text_px,
  output logic                   banner_vis
);
  logic [FONT_COLS-1:0] w_font;
  logic [2:0]           r_bit;
  logic                 r_on;
  logic                 r_video;
  logic [RGB_W-1:0]     r_bg;
  logic                 w_lit;
  state_t               r_state;
  state_t               w_state_nx;
  crash_font_rom u_rom (
    .clk     (clk),
    .reset_n (reset_n),
    .i_addr  (crash_rom_addr),
    .o_data  (w_font)
  );
  // stage 1 runs alongside the ROM read so both arrive at the mixer together
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_bit   <= '0;
      r_on    <= 1'b0;
      r_video <= 1'b0;
      r_bg    <= RGB_BLACK;
      rgb_out <= RGB_BLACK;
      text_px <= 1'b0;
    end else begin
      r_bit   <= crash_bit_addr;
      r_on    <= crash_on;
      r_video <= video_on;
      r_bg    <= bg_rgb;
      rgb_out <= !r_video ? RGB_BLACK : (w_lit ? TEXT_RGB : r_bg);
      text_px <= w_lit;
    end
  assign w_lit = w_font[~r_bit] & r_on & banner_vis & r_video;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state    <= IDLE;
      banner_vis <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      banner_vis <= (w_state_nx == SHOW) || (w_state_nx == BLINK_ON);
    end
`ifdef CRASH_TEXT_BLINK_EN
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nx;
  logic       w_last;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_cnt <= '0;
    else r_cnt <= w_cnt_nx;
  // dropping crash_en outranks a terminal frame_tick in the same cycle
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_last     = r_cnt == ((r_state == SHOW) ? 8'(SHOW_FRAMES - 1) : 8'(BLINK_FRAMES - 1));
    if (!crash_en) begin
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
    end else if (r_state == IDLE) begin
      w_state_nx = SHOW;
      w_cnt_nx   = '0;
    end else if (frame_tick) begin
      w_cnt_nx   = w_last ? 8'd0 : r_cnt + 8'd1;
      w_state_nx = !w_last ? r_state : ((r_state == BLINK_ON) ? BLINK_OFF : BLINK_ON);
    end
  end
`else
  logic w_unused_tick;
  localparam int unused_frames = SHOW_FRAMES + BLINK_FRAMES;
  assign w_unused_tick = frame_tick;
  always_comb w_state_nx = crash_en ? SHOW : IDLE;
`endif
endmodule

// File: tb/tb_crash_text_renderer.sv
// tb_crash_text_renderer: scoreboard bench for pixel pipeline, glyph gating and banner FSM
module tb_crash_text_renderer;
  typedef struct {
    int         at;
    bit         cp;
    logic [11:0] rgb;
    logic       tp;
    bit         cv;
    logic       vis;
    string      nm;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        crash_en;
  logic        frame_tick;
  logic        crash_on;
  logic [10:0] crash_rom_addr;
  logic [2:0]  crash_bit_addr;
  logic        video_on;
  logic [11:0] bg_rgb;
  logic [11:0] rgb_out;
  logic        text_px;
  logic        banner_vis;

  exp_t q[$];
  exp_t m_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef CRASH_TEXT_BLINK_EN
  bit vis_a [12] = '{1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
  bit vis_r [5]  = '{1, 1, 1, 1, 0};
`else
  bit vis_a [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  bit vis_r [5]  = '{1, 1, 1, 1, 1};
`endif

  // glyph probes: address, hand-read font row, background
  logic [10:0] g_addr [5] = '{{7'h44, 4'h5}, {7'h41, 4'h7}, {7'h52, 4'h2}, {7'h10, 4'h5}, {7'h21, 4'h3}};
  logic [7:0]  g_word [5] = '{8'h66, 8'hfe, 8'hfc, 8'h00, 8'h3c};
  logic [11:0] g_bg   [5] = '{12'h0A5, 12'h123, 12'h7E7, 12'hABC, 12'h00F};

  crash_text_renderer #(.SHOW_FRAMES(3), .BLINK_FRAMES(2), .TEXT_RGB(12'hF00)) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .crash_en       (crash_en),
    .frame_tick     (frame_tick),
    .crash_on       (crash_on),
    .crash_rom_addr (crash_rom_addr),
    .crash_bit_addr (crash_bit_addr),
    .video_on       (video_on),
    .bg_rgb         (bg_rgb),
    .rgb_out        (rgb_out),
    .text_px        (text_px),
    .banner_vis     (banner_vis)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      m_e = q.pop_front();
      if (m_e.at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: entry for cycle %0d checked at %0d", m_e.nm, m_e.at, cyc);
      end else begin
        if (m_e.cp) begin
          checks++;
          if (rgb_out !== m_e.rgb || text_px !== m_e.tp) begin
            errors++;
            $display("FAIL %s: rgb_out=%h text_px=%b, expected rgb_out=%h text_px=%b",
                     m_e.nm, rgb_out, text_px, m_e.rgb, m_e.tp);
          end
        end
        if (m_e.cv) begin
          checks++;
          if (banner_vis !== m_e.vis) begin
            errors++;
            $display("FAIL %s: banner_vis=%b, expected %b", m_e.nm, banner_vis, m_e.vis);
          end
        end
      end
    end
  end

  task automatic push(input int dly, input bit cp, input logic [11:0] rgb, input logic tp,
                      input bit cv, input logic vis, input string nm);
    exp_t e;
    e.at = cyc + dly; e.cp = cp; e.rgb = rgb; e.tp = tp; e.cv = cv; e.vis = vis; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic pix(input logic [10:0] a, input logic [2:0] b, input logic on, input logic vid,
                     input logic [11:0] bg, input logic lit, input string nm);
    @(negedge clk);
    crash_rom_addr = a;
    crash_bit_addr = b;
    crash_on       = on;
    video_on       = vid;
    bg_rgb         = bg;
    push(2, 1, !vid ? 12'h000 : (lit ? 12'hF00 : bg), lit, 0, 1'b0, nm);
  endtask

  task automatic tick(input logic en, input logic vis, input string nm);
    @(negedge clk);
    crash_en   = en;
    frame_tick = 1'b1;
    push(1, 0, 12'h000, 1'b0, 1, vis, nm);
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    reset_n = 1'b0; crash_en = 1'b0; frame_tick = 1'b0; crash_on = 1'b0;
    crash_rom_addr = '0; crash_bit_addr = '0; video_on = 1'b0; bg_rgb = '0;
    repeat (4) begin
      @(negedge clk);
      crash_en = 1'($urandom); frame_tick = 1'($urandom); crash_on = 1'($urandom);
      crash_rom_addr = 11'($urandom); crash_bit_addr = 3'($urandom);
      video_on = 1'($urandom); bg_rgb = 12'($urandom);
      push(1, 1, 12'h000, 1'b0, 1, 1'b0, "reset_hold");
    end
    @(negedge clk);
    reset_n = 1'b1; crash_en = 1'b0; frame_tick = 1'b0; crash_on = 1'b0; video_on = 1'b0;
    // banner idle: background passes through with 2-cycle latency even on lit glyph pixels
    for (int i = 0; i < 8; i++) pix({7'h44, 4'h5}, 3'd1, 1'b1, 1'b1, 12'($urandom), 1'b0, "latency_bg");
    for (int i = 0; i < 3; i++) pix({7'h44, 4'h5}, 3'd1, 1'b1, 1'b0, 12'($urandom), 1'b0, "latency_black");
    @(negedge clk);
    crash_en = 1'b1;
    push(1, 0, 12'h000, 1'b0, 1, 1'b1, "vis_rise");
    pix('0, 3'd0, 1'b0, 1'b1, 12'h456, 1'b0, "pre_glyph");
    pix('0, 3'd0, 1'b0, 1'b1, 12'h789, 1'b0, "pre_glyph");
    for (int g = 0; g < 5; g++) begin
      w = g_word[g];
      for (int b = 0; b < 8; b++)
        pix(g_addr[g], 3'(b), 1'b1, 1'b1, g_bg[g], w[3'(7 - b)], $sformatf("glyph%0d_bit%0d", g, b));
    end
    pix({7'h44, 4'h5}, 3'd1, 1'b1, 1'b0, 12'hFFF, 1'b0, "glyph_video_off");
    pix({7'h44, 4'h5}, 3'd1, 1'b0, 1'b1, 12'h321, 1'b0, "glyph_outside_region");
    pix({7'h44, 4'h5}, 3'd2, 1'b1, 1'b1, 12'h321, 1'b1, "glyph_back_on");
    for (int i = 0; i < 3; i++) pix('0, 3'd0, 1'b0, 1'b0, 12'h000, 1'b0, "glyph_idle");
    @(negedge clk);
    crash_en = 1'b0;
    push(1, 0, 12'h000, 1'b0, 1, 1'b0, "vis_fall");
    @(negedge clk);
    // entry tick coincides with crash_en and must not be counted
    @(negedge clk);
    crash_en = 1'b1; frame_tick = 1'b1;
    push(1, 0, 12'h000, 1'b0, 1, 1'b1, "enter_with_tick");
    @(negedge clk);
    frame_tick = 1'b0;
    for (int i = 0; i < 12; i++) tick(i < 10 ? 1'b1 : 1'b0, vis_a[i], $sformatf("fsm_tick%0d", i + 1));
    @(negedge clk);
    crash_en = 1'b1;
    push(1, 0, 12'h000, 1'b0, 1, 1'b1, "reassert");
    @(negedge clk);
    for (int i = 0; i < 5; i++) tick(1'b1, vis_r[i], $sformatf("restart_tick%0d", i + 1));
`ifndef CRASH_TEXT_BLINK_EN
    for (int i = 0; i < 500; i++) tick(1'b1, 1'b1, $sformatf("noblink_tick%0d", i + 1));
`endif
    @(negedge clk);
    crash_en = 1'b0;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
